// File: rtl/retospect_lif_neuron.sv
// Parametrised leaky integrate-and-fire neuron cell with a serial config chain.
// Define RETOSPECT_LIF_SPIKE_COUNT_EN to build the saturating 8-bit spike counter.
module retospect_lif_neuron #(
    parameter int N_DEND       = 4,
    parameter int W_BITS       = 3,
    parameter int POT_BITS     = 6,
    parameter int CLK_SEL_BITS = 3,
    parameter int REFR_BITS    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         reset_nn,
    input  logic                         config_en,
    input  logic                         bs_in,
    output logic                         bs_out,
    input  logic [2**CLK_SEL_BITS-1:0]   clockbus,
    input  logic [N_DEND-1:0]            dendrite,
    output logic                         axon,
    output logic [POT_BITS-1:0]          potential,
    output logic [7:0]                   spike_count
);

    localparam int L      = N_DEND*W_BITS + POT_BITS + CLK_SEL_BITS + REFR_BITS;
    localparam int TH_LSB = N_DEND*W_BITS;
    localparam int DS_LSB = TH_LSB + POT_BITS;
    localparam int RF_LSB = DS_LSB + CLK_SEL_BITS;
    localparam int SUM_W  = POT_BITS + W_BITS + $clog2(N_DEND) + 1;

    typedef enum logic [1:0] {
        S_INTEGRATE  = 2'd0,
        S_FIRE       = 2'd1,
        S_REFRACTORY = 2'd2
    } state_e;

    logic [L-1:0]         cfg_q, cfg_d;
    logic [POT_BITS-1:0]  pot_q, pot_d;
    state_e               state_q, state_d;
    logic [REFR_BITS-1:0] refr_cnt_q, refr_cnt_d;
    logic                 axon_q, axon_d;

    logic [POT_BITS-1:0]     thresh;
    logic [CLK_SEL_BITS-1:0] dsel;
    logic [REFR_BITS-1:0]    refr;
    logic [POT_BITS-1:0]     leak;
    logic [SUM_W-1:0]        dsum;
    logic [SUM_W-1:0]        raw_sum;
    logic [POT_BITS-1:0]     sat_pot;
    logic [W_BITS-1:0]       w_i;

    assign thresh = cfg_q[TH_LSB +: POT_BITS];
    assign dsel   = cfg_q[DS_LSB +: CLK_SEL_BITS];
    assign refr   = cfg_q[RF_LSB +: REFR_BITS];

    assign bs_out    = cfg_q[0];
    assign axon      = axon_q;
    assign potential = pot_q;

    // Sum is wide enough that neither the signed weights nor the leaked potential can wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        dsum = '0;
        w_i  = '0;
        for (int i = 0; i < N_DEND; i++) begin
            w_i = cfg_q[i*W_BITS +: W_BITS];
            if (dendrite[i]) begin
                dsum = dsum + {{(SUM_W-W_BITS){w_i[W_BITS-1]}}, w_i};
            end
        end
        leak    = clockbus[dsel] ? (pot_q >> 1) : pot_q;
        raw_sum = {{(SUM_W-POT_BITS){1'b0}}, leak} + dsum;
        if (raw_sum[SUM_W-1]) begin
            sat_pot = '0;
        end else if (|raw_sum[SUM_W-2:POT_BITS]) begin
            sat_pot = '1;
        end else begin
            sat_pot = raw_sum[POT_BITS-1:0];
        end
    end

    always_comb begin
        cfg_d      = cfg_q;
        pot_d      = pot_q;
        state_d    = state_q;
        refr_cnt_d = refr_cnt_q;
        axon_d     = 1'b0;
        if (reset_nn) begin
            pot_d      = '0;
            state_d    = S_INTEGRATE;
            refr_cnt_d = '0;
        end else if (config_en) begin
            cfg_d      = {bs_in, cfg_q[L-1:1]};
            state_d    = S_INTEGRATE;
            refr_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_INTEGRATE: begin
                    pot_d = sat_pot;
                    if ((thresh != '0) && (sat_pot >= thresh)) begin
                        state_d = S_FIRE;
                        pot_d   = '0;
                        axon_d  = 1'b1;
                    end
                end
                S_FIRE: begin
                    pot_d = '0;
                    if (refr == '0) begin
                        state_d = S_INTEGRATE;
                    end else begin
                        state_d    = S_REFRACTORY;
                        refr_cnt_d = refr;
                    end
                end
                S_REFRACTORY: begin
                    pot_d      = '0;
                    refr_cnt_d = refr_cnt_q - 1'b1;
                    if (refr_cnt_q <= REFR_BITS'(1)) begin
                        state_d    = S_INTEGRATE;
                        refr_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = S_INTEGRATE;
                    pot_d   = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q      <= '0;
            pot_q      <= '0;
            state_q    <= S_INTEGRATE;
            refr_cnt_q <= '0;
            axon_q     <= 1'b0;
        end else begin
            cfg_q      <= cfg_d;
            pot_q      <= pot_d;
            state_q    <= state_d;
            refr_cnt_q <= refr_cnt_d;
            axon_q     <= axon_d;
        end
    end

`ifdef RETOSPECT_LIF_SPIKE_COUNT_EN
    logic [7:0] spk_cnt_q, spk_cnt_d;

    always_comb begin
        spk_cnt_d = spk_cnt_q;
        if (reset_nn) begin
            spk_cnt_d = '0;
        end else if (!config_en && (state_q == S_FIRE) && (spk_cnt_q != 8'hFF)) begin
            spk_cnt_d = spk_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spk_cnt_q <= '0;
        end else begin
            spk_cnt_q <= spk_cnt_d;
        end
    end

    assign spike_count = spk_cnt_q;
`else
    assign spike_count = '0;
`endif

endmodule

// File: tb/tb_retospect_lif_neuron.sv
// Directed-vector bench for retospect_lif_neuron at default parameters.
// Covers the config chain, firing, inhibition, saturation, leak and refractory timing.
module tb_retospect_lif_neuron;

    localparam int L = 23;

    logic       clk;
    logic       reset;
    logic       reset_nn;
    logic       config_en;
    logic       bs_in;
    logic       bs_out;
    logic [7:0] clockbus;
    logic [3:0] dendrite;
    logic       axon;
    logic [5:0] potential;
    logic [7:0] spike_count;

    int total = 0;
    int bad   = 0;

    retospect_lif_neuron dut (
        .clk         (clk),
        .reset       (reset),
        .reset_nn    (reset_nn),
        .config_en   (config_en),
        .bs_in       (bs_in),
        .bs_out      (bs_out),
        .clockbus    (clockbus),
        .dendrite    (dendrite),
        .axon        (axon),
        .potential   (potential),
        .spike_count (spike_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [L-1:0] make_cfg(input logic [2:0] w0, input logic [2:0] w1,
                                              input logic [2:0] w2, input logic [2:0] w3,
                                              input logic [5:0] th, input logic [2:0] ds,
                                              input logic [1:0] rf);
        return {rf, ds, th, w3, w2, w1, w0};
    endfunction

    task automatic load_cfg(input logic [L-1:0] word);
        for (int i = 0; i < L; i++) begin
            bs_in     = word[i];
            config_en = 1'b1;
            tick();
        end
        config_en = 1'b0;
        bs_in     = 1'b0;
    endtask

    task automatic soft_reset();
        reset_nn = 1'b1;
        tick();
        reset_nn = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        config_en = 1'b1;
        bs_in     = 1'b1;
        dendrite  = 4'hF;
        tick();
        tick();
        total++;
        if (axon !== 1'b0) begin bad++; $display("FAIL reset_axon got=%b want=0", axon); end
        total++;
        if (potential !== 6'd0) begin bad++; $display("FAIL reset_pot got=%0d want=0", potential); end
        total++;
        if (bs_out !== 1'b0) begin bad++; $display("FAIL reset_bs_out got=%b want=0", bs_out); end
        total++;
        if (spike_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", spike_count); end
        reset     = 1'b0;
        config_en = 1'b0;
        bs_in     = 1'b0;
        dendrite  = 4'h0;
    endtask

    task automatic test_chain();
        logic [L-1:0] p;
        p = 23'h35A60D;
        for (int i = 0; i < L; i++) begin
            bs_in     = p[i];
            config_en = 1'b1;
            tick();
            total++;
            if (i < L - 1) begin
                if (bs_out !== 1'b0) begin bad++; $display("FAIL chain_early%0d got=%b want=0", i, bs_out); end
            end else begin
                if (bs_out !== p[0]) begin bad++; $display("FAIL chain_first got=%b want=%b", bs_out, p[0]); end
            end
        end
        for (int i = 1; i <= 3; i++) begin
            bs_in = 1'b0;
            tick();
            total++;
            if (bs_out !== p[i]) begin bad++; $display("FAIL chain_replay%0d got=%b want=%b", i, bs_out, p[i]); end
        end
        total++;
        if (potential !== 6'd0 || axon !== 1'b0) begin
            bad++; $display("FAIL chain_quiet pot=%0d axon=%b want 0/0", potential, axon);
        end
        config_en = 1'b0;
    endtask

    task automatic test_fire();
        load_cfg(make_cfg(3'd3, 3'd0, 3'd0, 3'd0, 6'd6, 3'd0, 2'd0));
        soft_reset();
        dendrite = 4'b0001;
        tick();
        total++;
        if (potential !== 6'd3 || axon !== 1'b0) begin
            bad++; $display("FAIL fire_c1 pot=%0d axon=%b want 3/0", potential, axon);
        end
        tick();
        dendrite = 4'b0000;
        total++;
        if (potential !== 6'd0 || axon !== 1'b1) begin
            bad++; $display("FAIL fire_c2 pot=%0d axon=%b want 0/1", potential, axon);
        end
        tick();
        total++;
        if (potential !== 6'd0 || axon !== 1'b0) begin
            bad++; $display("FAIL fire_c3 pot=%0d axon=%b want 0/0", potential, axon);
        end
        tick();
        total++;
        if (axon !== 1'b0) begin bad++; $display("FAIL fire_c4 axon got=%b want=0", axon); end
    endtask

    task automatic test_inhibit();
        logic [5:0] exp_pot [3];
        logic [3:0] stim    [3];
        exp_pot = '{6'd3, 6'd1, 6'd0};
        stim    = '{4'b0001, 4'b0010, 4'b0010};
        load_cfg(make_cfg(3'd3, 3'b110, 3'd0, 3'd0, 6'd0, 3'd0, 2'd0));
        soft_reset();
        for (int k = 0; k < 3; k++) begin
            dendrite = stim[k];
            tick();
            total++;
            if (potential !== exp_pot[k]) begin
                bad++; $display("FAIL inhibit%0d got=%0d want=%0d", k, potential, exp_pot[k]);
            end
        end
        dendrite = 4'h0;
    endtask

    task automatic test_saturate();
        int exp_pot;
        load_cfg(make_cfg(3'd3, 3'd3, 3'd2, 3'd1, 6'd0, 3'd0, 2'd0));
        soft_reset();
        dendrite = 4'hF;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_pot = (9 * k > 63) ? 63 : 9 * k;
            total++;
            if (potential !== 6'(exp_pot) || axon !== 1'b0) begin
                bad++; $display("FAIL saturate%0d pot=%0d axon=%b want %0d/0", k, potential, axon, exp_pot);
            end
        end
        dendrite = 4'h0;
    endtask

    task automatic test_leak();
        logic [5:0] exp_pot [4];
        exp_pot = '{6'd6, 6'd3, 6'd1, 6'd0};
        load_cfg(make_cfg(3'd3, 3'd0, 3'd0, 3'd0, 6'd0, 3'd1, 2'd0));
        soft_reset();
        clockbus = 8'h00;
        dendrite = 4'b0001;
        repeat (4) tick();
        dendrite = 4'h0;
        total++;
        if (potential !== 6'd12) begin bad++; $display("FAIL leak_build got=%0d want=12", potential); end
        clockbus = 8'h01;
        tick();
        total++;
        if (potential !== 6'd12) begin bad++; $display("FAIL leak_wrong_strobe got=%0d want=12", potential); end
        clockbus = 8'h02;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (potential !== exp_pot[k]) begin
                bad++; $display("FAIL leak%0d got=%0d want=%0d", k, potential, exp_pot[k]);
            end
        end
        clockbus = 8'h00;
    endtask

    task automatic test_refractory();
        logic       exp_axon;
        logic [7:0] exp_cnt;
        load_cfg(make_cfg(3'd3, 3'd0, 3'd0, 3'd0, 6'd3, 3'd0, 2'd2));
        soft_reset();
        dendrite = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_axon = (k % 4 == 1);
            total++;
            if (axon !== exp_axon) begin
                bad++; $display("FAIL refr_axon%0d got=%b want=%b", k, axon, exp_axon);
            end
        end
`ifdef RETOSPECT_LIF_SPIKE_COUNT_EN
        exp_cnt = 8'd3;
`else
        exp_cnt = 8'd0;
`endif
        total++;
        if (spike_count !== exp_cnt) begin
            bad++; $display("FAIL refr_count got=%0d want=%0d", spike_count, exp_cnt);
        end
        dendrite = 4'h0;
        reset_nn = 1'b1;
        tick();
        reset_nn = 1'b0;
        total++;
        if (spike_count !== 8'd0 || axon !== 1'b0 || potential !== 6'd0) begin
            bad++; $display("FAIL refr_soft_reset cnt=%0d axon=%b pot=%0d want 0/0/0", spike_count, axon, potential);
        end
        dendrite = 4'b0001;
        tick();
        total++;
        if (axon !== 1'b1) begin bad++; $display("FAIL refr_abort_fire got=%b want=1", axon); end
        tick();
        tick();
        config_en = 1'b1;
        bs_in     = 1'b0;
        dendrite  = 4'h0;
        tick();
        config_en = 1'b0;
        load_cfg(make_cfg(3'd3, 3'd0, 3'd0, 3'd0, 6'd3, 3'd0, 2'd2));
        dendrite = 4'b0001;
        tick();
        total++;
        if (axon !== 1'b1) begin bad++; $display("FAIL refr_cfg_abort got=%b want=1", axon); end
        dendrite = 4'h0;
    endtask

    initial begin
        reset     = 1'b1;
        reset_nn  = 1'b0;
        config_en = 1'b0;
        bs_in     = 1'b0;
        clockbus  = 8'h00;
        dendrite  = 4'h0;
        test_reset();
        test_chain();
        test_fire();
        test_inhibit();
        test_saturate();
        test_leak();
        test_refractory();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
